// File: rtl/regfile_dump_unit.sv
// regfile_dump_unit: walks a wrap-around register range through both read ports and streams {addr, data} beats
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
module regfile_dump_unit #(
    parameter int DATA_WIDTH     = `DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [REG_ADDR_WIDTH-1:0] first_addr,
    input  logic [REG_ADDR_WIDTH-1:0] last_addr,
    output logic                      rf_read_enable,
    output logic [REG_ADDR_WIDTH-1:0] rf_rs1_addr,
    output logic [REG_ADDR_WIDTH-1:0] rf_rs2_addr,
    input  logic [DATA_WIDTH-1:0]     rf_rs1,
    input  logic [DATA_WIDTH-1:0]     rf_rs2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [REG_ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);
    typedef enum logic [2:0] {IDLE, RD, TX0, TX1, DONE} state_t;
    localparam logic [REG_ADDR_WIDTH:0] ONE = 1;
    localparam logic [REG_ADDR_WIDTH:0] TWO = 2;
    state_t                    state;
    logic [REG_ADDR_WIDTH-1:0] cur;
    logic [REG_ADDR_WIDTH:0]   rem;
    logic [DATA_WIDTH-1:0]     hold1;
    logic [REG_ADDR_WIDTH-1:0] span;
    assign span = last_addr - first_addr;
    // Sequencer; every output is a register loaded on the edge that enters the state it belongs to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cur            <= '0;
            rem            <= '0;
            hold1          <= '0;
            rf_read_enable <= 1'b0;
            rf_rs1_addr    <= '0;
            rf_rs2_addr    <= '0;
            out_valid      <= 1'b0;
            out_addr       <= '0;
            out_data       <= '0;
            out_last       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state          <= RD;
                    cur            <= first_addr;
                    rem            <= {1'b0, span} + ONE;
                    rf_read_enable <= 1'b1;
                    rf_rs1_addr    <= first_addr;
                    rf_rs2_addr    <= first_addr + 1'b1;
                    busy           <= 1'b1;
                end
                RD: begin
                    state          <= TX0;
                    hold1          <= rf_rs2;
                    rf_read_enable <= 1'b0;
                    rf_rs1_addr    <= '0;
                    rf_rs2_addr    <= '0;
                    out_valid      <= 1'b1;
                    out_addr       <= cur;
                    out_data       <= rf_rs1;
                    out_last       <= (rem == ONE);
                end
                TX0, TX1: if (out_ready) begin
                    if (rem == ONE) begin
                        state     <= DONE;
                        out_valid <= 1'b0;
                        out_addr  <= '0;
                        out_data  <= '0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                    end else if (state == TX0) begin
                        state    <= TX1;
                        rem      <= rem - ONE;
                        out_addr <= cur + 1'b1;
                        out_data <= hold1;
                        out_last <= (rem == TWO);
                    end else begin
                        state          <= RD;
                        rem            <= rem - ONE;
                        cur            <= cur + 2'd2;
                        out_valid      <= 1'b0;
                        out_addr       <= '0;
                        out_data       <= '0;
                        out_last       <= 1'b0;
                        rf_read_enable <= 1'b1;
                        rf_rs1_addr    <= cur + 2'd2;
                        rf_rs2_addr    <= cur + 2'd3;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_dump_unit.sv
// tb_regfile_dump_unit: table-driven and randomized dumps checked against a beat-list model of the range
module tb_regfile_dump_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  first_addr = '0;
    logic [4:0]  last_addr = '0;
    logic        rf_read_enable;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr;
    logic [31:0] rf_rs1, rf_rs2;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last, busy, done;
    logic [31:0] regs [32];
    logic [4:0]  rs2_log [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic [4:0] f;
        logic [4:0] l;
        int         rpct;
        int         stall_addr;
        bit         poke;
        int         exp_n;
        int         exp_cyc;
    } vec_t;
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic        last;
    } beat_t;

    regfile_dump_unit dut (
        .clk(clk), .rst(rst), .start(start), .first_addr(first_addr), .last_addr(last_addr),
        .rf_read_enable(rf_read_enable), .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
    );

    assign rf_rs1 = regs[rf_rs1_addr];
    assign rf_rs2 = regs[rf_rs2_addr];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int rpct,
                            input int stall_addr, input bit poke, input int exp_n, input int exp_cyc);
        beat_t       q [$];
        beat_t       b;
        int          n, k, got, stall;
        bit          pv;
        logic [4:0]  pa, span, nx;
        logic [31:0] pd;
        logic        pl;
        span = l - f;
        n = int'(span) + 1;
        if (exp_n < 0) exp_n = n;
        for (int i = 0; i < n; i++) begin
            b.a = f + 5'(i);
            b.d = regs[b.a];
            b.last = (i == n - 1);
            q.push_back(b);
        end
        rs2_log.delete();
        @(negedge clk);
        start = 1'b1; first_addr = f; last_addr = l; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; first_addr = 5'($urandom); last_addr = 5'($urandom);
        k = 0; got = 0; stall = 0; pv = 1'b0; pa = '0; pd = '0; pl = 1'b0;
        while (!done && k < 3000) begin
            check("busy", busy, 1);
            if (pv) begin
                check("hold_valid", out_valid, 1);
                check("hold_addr", out_addr, pa);
                check("hold_data", out_data, pd);
                check("hold_last", out_last, pl);
            end
            if (rf_read_enable) begin
                nx = (q.size() != 0) ? q[0].a : 5'd0;
                check("rs1_addr", rf_rs1_addr, nx);
                nx = nx + 5'd1;
                check("rs2_addr", rf_rs2_addr, nx);
                rs2_log.push_back(rf_rs2_addr);
            end else begin
                check("rf_idle", {rf_rs1_addr, rf_rs2_addr}, 0);
            end
            if (poke) start = (k == 4);
            if (out_valid && out_addr == stall_addr && stall < 5) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = ($urandom_range(99) < rpct);
            end
            if (out_valid && out_ready) begin
                check("extra_beat", q.size() == 0, 0);
                if (q.size() != 0) begin
                    b = q.pop_front();
                    check("beat_addr", out_addr, b.a);
                    check("beat_data", out_data, b.d);
                    check("beat_last", out_last, b.last);
                end
                got++;
            end
            pv = out_valid && !out_ready;
            pa = out_addr; pd = out_data; pl = out_last;
            k++;
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", done, 1);
        check("beat_count", got, exp_n);
        if (exp_cyc >= 0) check("done_cycle", k, exp_cyc);
        check("done_outputs", {out_valid, out_last, rf_read_enable, busy}, 4'b0001);
        start = 1'b1; first_addr = 5'($urandom); last_addr = 5'($urandom);
        @(negedge clk);
        start = 1'b0;
        check("idle_after_done", {busy, done, rf_read_enable, out_valid}, 0);
        @(negedge clk);
        check("still_idle", busy, 0);
    endtask

    initial begin
        vec_t        vecs [6];
        logic [4:0]  f, l;
        int          k;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'h0;
        regs[1] = 32'h12345678;
        regs[2] = 32'hAABBCCDD;
        regs[31] = 32'h5555AAAA;
        regs[3] = 32'h3; regs[4] = 32'h4; regs[5] = 32'h5;
        #1;
        check("reset_outputs", {out_valid, out_last, busy, done, rf_read_enable,
                                rf_rs1_addr, rf_rs2_addr, out_addr, out_data}, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {busy, done, out_valid, rf_read_enable}, 0);

        vecs[0] = '{f: 5'd0,  l: 5'd31, rpct: 100, stall_addr: -1, poke: 1'b0, exp_n: 32, exp_cyc: 48};
        vecs[1] = '{f: 5'd3,  l: 5'd5,  rpct: 100, stall_addr: -1, poke: 1'b0, exp_n: 3,  exp_cyc: 5};
        vecs[2] = '{f: 5'd30, l: 5'd1,  rpct: 100, stall_addr: -1, poke: 1'b0, exp_n: 4,  exp_cyc: 6};
        vecs[3] = '{f: 5'd0,  l: 5'd9,  rpct: 100, stall_addr: 2,  poke: 1'b0, exp_n: 10, exp_cyc: 20};
        vecs[4] = '{f: 5'd4,  l: 5'd12, rpct: 100, stall_addr: -1, poke: 1'b1, exp_n: 9,  exp_cyc: 14};
        vecs[5] = '{f: 5'd7,  l: 5'd7,  rpct: 100, stall_addr: -1, poke: 1'b0, exp_n: 1,  exp_cyc: 2};
        for (int i = 0; i < 6; i++) begin
            run_dump(vecs[i].f, vecs[i].l, vecs[i].rpct, vecs[i].stall_addr, vecs[i].poke,
                     vecs[i].exp_n, vecs[i].exp_cyc);
            if (i == 2) begin
                check("wrap_rd_count", rs2_log.size(), 2);
                if (rs2_log.size() == 2) begin
                    check("wrap_rs2_first", rs2_log[0], 31);
                    check("wrap_rs2_second", rs2_log[1], 1);
                end
            end
        end

        @(negedge clk);
        start = 1'b1; first_addr = 5'd0; last_addr = 5'd9; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(out_valid && out_addr == 5'd3) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("reached_tx1", {out_valid, out_addr}, {1'b1, 5'd3});
        #2 rst = 1'b1;
        #1;
        check("rst_abort_outputs", {out_valid, out_last, busy, done, rf_read_enable,
                                    rf_rs1_addr, rf_rs2_addr, out_addr, out_data}, 0);
        repeat (3) begin
            @(posedge clk);
            #1 check("rst_no_done", {done, busy, out_valid}, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_no_done", {done, busy}, 0);
        run_dump(5'd0, 5'd9, 100, -1, 1'b0, 10, 15);

        for (int t = 0; t < 20; t++) begin
            for (int i = 1; i < 32; i++) regs[i] = $urandom;
            f = 5'($urandom);
            l = 5'($urandom);
            run_dump(f, l, $urandom_range(100, 30), -1, 1'($urandom_range(1)), -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
